// File: rtl/rr_muxn.sv
// N-to-1 mux with fixed-select or round-robin arbitration into a one-entry output register.
// One cycle from grant to out_valid; a stalled output blocks all grants (in_ready stays 0).
module rr_muxn #(
   parameter  int N  = 8,
   parameter  int W  = 8,
   localparam int SW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N*W-1:0] in_data,
   input  logic [N-1:0]   in_valid,
   output logic [N-1:0]   in_ready,
   input  logic           mode,
   input  logic [SW-1:0]  sel,
   output logic [W-1:0]   out_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [SW-1:0]  out_ch
);

   logic [SW-1:0] ptr;
   logic          load;
   logic          gvld;
   logic [SW-1:0] gidx;
   logic [N-1:0]  grant;
   int            idx;

   assign load = !out_valid || out_ready;

   // rst gates the grant so in_ready is zero for the whole reset interval.
   always_comb begin
      gvld  = 1'b0;
      gidx  = '0;
      grant = '0;
      idx   = 0;
      if (!rst && load) begin
         if (mode) begin
            for (int k = 0; k < N; k++) begin
               idx = (int'(ptr) + k) % N;
               if (!gvld && in_valid[idx]) begin
                  gvld = 1'b1;
                  gidx = SW'(idx);
               end
            end
         end else if (int'(sel) < N) begin
            if (in_valid[sel]) begin
               gvld = 1'b1;
               gidx = sel;
            end
         end
      end
      if (gvld) grant[gidx] = 1'b1;
   end

   assign in_ready = grant;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         ptr       <= '0;
      end else begin
         if (gvld) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(gidx)*W +: W];
            out_ch    <= gidx;
            if (mode) ptr <= (int'(gidx) == N-1) ? '0 : gidx + SW'(1);
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rr_muxn.sv
// Directed-vector bench for rr_muxn (N=8, W=8) with hand-computed expectations.
module tb_rr_muxn;

   localparam int N  = 8;
   localparam int W  = 8;
   localparam int SW = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid;
   logic [N-1:0]   in_ready;
   logic           mode;
   logic [SW-1:0]  sel;
   logic [W-1:0]   out_data;
   logic           out_valid;
   logic           out_ready;
   logic [SW-1:0]  out_ch;

   int checks = 0;
   int errors = 0;

   rr_muxn #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .sel       (sel),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ch    (out_ch)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic default_data();
      for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'h10 + 8'(i);
   endtask

   task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic [2:0] c);
      check({tag, ".valid"}, 32'(out_valid), 32'(v));
      check({tag, ".data"},  32'(out_data),  32'(d));
      check({tag, ".ch"},    32'(out_ch),    32'(c));
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; mode = 1'b1; sel = '0; in_valid = 8'hFF; out_ready = 1'b1;
      default_data();
      #2;
      check("rst_ready", 32'(in_ready), 32'h0);
      check_out("rst_out", 1'b0, 8'h00, 3'd0);
      tick(); tick();
      check("rst_ready2", 32'(in_ready), 32'h0);

      // Round robin after reset: 0..7,0,1
      rst = 1'b0;
      #1;
      for (int i = 0; i < 10; i++) begin
         check($sformatf("rr_ready%0d", i), 32'(in_ready), 32'(1 << (i % 8)));
         tick();
         check_out($sformatf("rr_out%0d", i), 1'b1, 8'h10 + 8'(i % 8), 3'(i % 8));
      end
      // ptr now 2

      // Fixed select of ch5
      mode = 1'b0; sel = 3'd5; in_valid = 8'h20; in_data[5*W +: W] = 8'hA5;
      #1;
      check("fix_ready", 32'(in_ready), 32'h20);
      tick();
      check_out("fix_out", 1'b1, 8'hA5, 3'd5);
      default_data();

      // Fixed select of idle channel: no grant, pending word drains, data holds
      sel = 3'd3; in_valid = 8'h00;
      #1;
      check("idle_ready", 32'(in_ready), 32'h0);
      tick();
      check_out("drain_out", 1'b0, 8'hA5, 3'd5);
      in_valid = 8'hF7;
      #1;
      check("selnv_ready", 32'(in_ready), 32'h0);

      // RR from ptr=2 with only ch0 valid -> ch0, ptr=1
      mode = 1'b1; in_valid = 8'h01;
      #1;
      check("wrap_ready", 32'(in_ready), 32'h01);
      tick();
      check_out("wrap_out", 1'b1, 8'h10, 3'd0);

      // ptr=1, in_valid=81 -> ch7 then ch0
      in_valid = 8'h81;
      #1;
      check("p1_ready", 32'(in_ready), 32'h80);
      tick();
      check_out("p1_out", 1'b1, 8'h17, 3'd7);
      check("p0_ready", 32'(in_ready), 32'h01);
      tick();
      check_out("p0_out", 1'b1, 8'h10, 3'd0);

      // Stall for 3 cycles: no grant, output and ptr frozen
      out_ready = 1'b0; in_valid = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("stall_ready%0d", i), 32'(in_ready), 32'h0);
         tick();
         check_out($sformatf("stall_out%0d", i), 1'b1, 8'h10, 3'd0);
      end
      out_ready = 1'b1;
      #1;
      check("unstall_ready", 32'(in_ready), 32'h02);
      tick();
      check_out("unstall_out", 1'b1, 8'h11, 3'd1);

      // Mode/sel change takes effect in the same cycle (ptr=2)
      mode = 1'b0; sel = 3'd6;
      #1;
      check("mc_fix_ready", 32'(in_ready), 32'h40);
      mode = 1'b1;
      #1;
      check("mc_rr_ready", 32'(in_ready), 32'h04);
      tick();
      check_out("mc_rr_out", 1'b1, 8'h12, 3'd2);
      mode = 1'b0;
      #1;
      check("mc_fix2_ready", 32'(in_ready), 32'h40);
      tick();
      check_out("mc_fix2_out", 1'b1, 8'h16, 3'd6);
      mode = 1'b1;
      #1;
      check("mc_ptr_ready", 32'(in_ready), 32'h08);

      // Reset mid-transfer clears output before any edge
      out_ready = 1'b0;
      tick();
      check_out("hold_out", 1'b1, 8'h16, 3'd6);
      rst = 1'b1;
      #1;
      check_out("arst_out", 1'b0, 8'h00, 3'd0);
      check("arst_ready", 32'(in_ready), 32'h0);
      tick();
      rst = 1'b0; out_ready = 1'b1;
      #1;
      check("post_rst_ready", 32'(in_ready), 32'h01);
      tick();
      check_out("post_rst_out", 1'b1, 8'h10, 3'd0);
      check("post_rst_ready2", 32'(in_ready), 32'h02);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_muxn.md
RR_MUXN -- requirements
Module: rr_muxn

Interface
REQ-001 Parameter N, default 8: number of input channels; legal range 2..16.
REQ-002 Parameter W, default 8: data width per channel in bits; legal range 1..64.
REQ-003 Derived constant SW = clog2(N): select and channel-index width.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 in_data  input  N*W  channel i occupies bits [i*W +: W].
REQ-008 in_valid  input  N  channel i presents a word.
REQ-009 in_ready  output  N  channel i word accepted this cycle; one-hot or zero.
REQ-010 mode  input  1  0 = fixed select; 1 = round-robin.
REQ-011 sel  input  SW  channel index used in fixed mode.
REQ-012 out_data  output  W  registered selected word.
REQ-013 out_valid  output  1  out_data and out_ch hold a word.
REQ-014 out_ready  input  1  downstream accepts the word.
REQ-015 out_ch  output  SW  source channel index of out_data.

Function
REQ-016 The block SHALL contain a one-entry output register and a round-robin pointer ptr of width SW.
REQ-017 load = !out_valid | out_ready; no grant SHALL be issued when load is 0.
REQ-018 Fixed mode: grant channel sel when load and in_valid[sel]; sel >= N SHALL grant nothing.
REQ-019 Round-robin mode: grant the first channel with in_valid set, searching ptr, ptr+1, ... N-1, 0, ... ptr-1.
REQ-020 On a round-robin grant to channel g, ptr SHALL become g+1, or 0 when g = N-1.
REQ-021 ptr SHALL not change in fixed mode or on cycles without a grant.
REQ-022 in_ready SHALL be combinational, equal to the one-hot grant, and at most one bit SHALL be set.
REQ-023 On a grant to channel g, the next edge SHALL load in_data[g*W +: W] into out_data and g into out_ch, and set out_valid.
REQ-024 On out_valid & out_ready without a grant, the next edge SHALL clear out_valid; out_data and out_ch SHALL hold.
REQ-025 While out_valid & !out_ready, out_data and out_ch SHALL stay stable.
REQ-026 Latency: 1 cycle from grant to out_valid. Throughput: one word per cycle while out_ready stays high.
REQ-027 A change of mode or sel SHALL take effect on the same cycle's grant decision. No word SHALL be lost or duplicated across the change.
REQ-028 in_valid deasserted for an ungranted channel SHALL have no effect on state.

Reset
REQ-029 While rst is high: out_valid = 0, out_data = 0, out_ch = 0, ptr = 0, and in_ready = 0.
REQ-030 Reset asserted mid-transfer SHALL discard the held word immediately without waiting for a clock edge.
REQ-031 The first grant after rst falls SHALL occur no earlier than the first rising edge with rst low.

Verification
REQ-032 N=8, W=8, mode=0, sel=5, in_valid=8'h20, in_data ch5=8'hA5, out_ready=1 -> in_ready=8'h20; next cycle out_valid=1, out_data=8'hA5, out_ch=5.
REQ-033 mode=1, in_valid=8'hFF held, out_ready=1, 10 cycles after reset -> out_ch sequence 0,1,2,3,4,5,6,7,0,1.
REQ-034 mode=1, in_valid=8'h81, ptr=1 -> grant ch7, ptr becomes 0; next grant ch0, ptr becomes 1.
REQ-035 out_valid=1, out_ready=0 for 3 cycles, in_valid=8'hFF -> in_ready=0; out_data and out_ch are unchanged; ptr is unchanged.
REQ-036 mode=0, sel=3, in_valid=8'h00 -> no grant, and out_valid falls after the pending word drains.
REQ-037 rst pulsed while out_valid=1 -> out_valid=0 and out_data=0 before the next edge; after release, round-robin restarts at ch0.
